// File: rtl/mem_arb_pkg.sv
// Shared state encoding, owner tags and counter sizing for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    // Bits needed to hold the range 0..maxVal, never fewer than one.
    function automatic int unsigned widthFor(input int unsigned maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Serializes instruction-fetch and load/store accesses onto one memory port;
// data wins by default, with a streak limit guarding fetch against starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        InstReq,
    input  logic [31:0] InstAddr,
    output logic        InstReady,
    output logic [31:0] InstData,
    input  logic        DataReq,
    input  logic        DataWrite,
    input  logic [31:0] DataAddr,
    input  logic [31:0] DataWData,
    output logic        DataReady,
    output logic [31:0] DataRData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemRData
);

    localparam int unsigned CW = widthFor(LATENCY - 1);
    localparam int unsigned SW = widthFor(MAX_STREAK);

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] cnt;
    logic [SW-1:0] streak;
    logic          owner;
    logic          writeQ;
    logic [31:0]   addrQ;
    logic [31:0]   wdataQ;
    logic          grant;
    logic          grantData;
    logic          lastCycle;

    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        grantData = 1'b0;
        lastCycle = (cnt == '0);
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        InstReady = 1'b0;
        DataReady = 1'b0;
        MemAddr   = addrQ;
        MemWData  = wdataQ;
        unique case (state)
            IDLE: begin
                if (InstReq || DataReq) begin
                    grant     = 1'b1;
                    grantData = DataReq && !(InstReq && (streak == SW'(MAX_STREAK)));
                    stateNext = ACCESS;
                end
            end
            ACCESS: begin
                MemRead = !writeQ;
                // A store whose final cycle coincides with reset must not reach memory.
                MemWrite = lastCycle && writeQ && !Reset;
                if (lastCycle) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                InstReady = (owner == OWN_INST);
                DataReady = (owner == OWN_DATA);
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            owner     <= OWN_INST;
            writeQ    <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            InstData  <= '0;
            DataRData <= '0;
        end else begin
            state <= stateNext;
            if (grant) begin
                owner  <= grantData ? OWN_DATA : OWN_INST;
                addrQ  <= grantData ? DataAddr : InstAddr;
                wdataQ <= grantData ? DataWData : '0;
                writeQ <= grantData && DataWrite;
                cnt    <= CW'(LATENCY - 1);
                if (grantData && InstReq) begin
                    if (streak != SW'(MAX_STREAK)) begin
                        streak <= streak + 1'b1;
                    end
                end else begin
                    streak <= '0;
                end
            end
            if (state == ACCESS) begin
                if (!lastCycle) begin
                    cnt <= cnt - 1'b1;
                end else if (!writeQ) begin
                    if (owner == OWN_DATA) begin
                        DataRData <= MemRData;
                    end else begin
                        InstData <= MemRData;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Two arbiter lanes (LATENCY 2 and 1) driven by directed and random traffic,
// each checked every cycle against a timestamp-based reference model.
module tb_mem_arbiter;

    localparam int MAXS = 4;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int nAsserts = 0;
    int nFails   = 0;

    task automatic check(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL lat%0d %s: got %h, expected %h at %0t", lat, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 2 : 1;

        logic        Reset, InstReq, InstReady, DataReq, DataWrite, DataReady, MemRead, MemWrite;
        logic [31:0] InstAddr, InstData, DataAddr, DataWData, DataRData;
        logic [31:0] MemAddr, MemWData, MemRData;
        logic [7:0]  mem    [0:4095];
        logic [7:0]  refMem [0:4095];
        bit          fin = 1'b0;

        // Reference model state: an access granted at the end of cycle gc owns
        // cycles gc+1..gc+LAT for memory and pulses Ready in cycle gc+LAT+1.
        int          cyc = 0;
        int          gc = 0;
        int          streak = 0;
        bit          started = 1'b0, busy = 1'b0, own = 1'b0, wr = 1'b0, fresh = 1'b0;
        logic [31:0] ad = '0, wd = '0, expI = '0, expD = '0;
        bit          ordLog[$];

        mem_arbiter #(.LATENCY(LAT), .MAX_STREAK(MAXS)) dut (
            .Clk(Clk), .Reset(Reset),
            .InstReq(InstReq), .InstAddr(InstAddr), .InstReady(InstReady), .InstData(InstData),
            .DataReq(DataReq), .DataWrite(DataWrite), .DataAddr(DataAddr), .DataWData(DataWData),
            .DataReady(DataReady), .DataRData(DataRData),
            .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead), .MemWrite(MemWrite),
            .MemRData(MemRData)
        );

        assign MemRData = {mem[MemAddr[11:0]], mem[MemAddr[11:0] + 12'd1],
                           mem[MemAddr[11:0] + 12'd2], mem[MemAddr[11:0] + 12'd3]};

        always @(negedge Clk) begin
            if (MemWrite) begin
                for (int b = 0; b < 4; b++) mem[12'(MemAddr + b)] <= MemWData[31 - 8*b -: 8];
            end
        end

        always @(posedge Clk) begin : model
            logic [31:0] v;
            if (Reset) begin
                started = 1'b1; busy = 1'b0; streak = 0;
                expI = '0; expD = '0; fresh = 1'b1;
            end else if (!busy) begin
                if (InstReq || DataReq) begin
                    own    = DataReq && !(InstReq && streak == MAXS);
                    wr     = own && DataWrite;
                    ad     = own ? DataAddr : InstAddr;
                    wd     = DataWData;
                    streak = (own && InstReq) ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                    gc     = cyc;
                    busy   = 1'b1;
                    fresh  = 1'b0;
                end
            end else if (cyc == gc + LAT) begin
                if (wr) begin
                    for (int b = 0; b < 4; b++) refMem[12'(ad + b)] = wd[31 - 8*b -: 8];
                end else begin
                    v = {refMem[12'(ad)], refMem[12'(ad + 1)], refMem[12'(ad + 2)], refMem[12'(ad + 3)]};
                    if (own) expD = v; else expI = v;
                end
            end else if (cyc == gc + LAT + 1) begin
                busy = 1'b0;
            end
            cyc++;
        end

        always @(negedge Clk) begin : compare
            bit acc, last, rdy;
            if (started) begin
                acc  = busy && cyc > gc && cyc <= gc + LAT;
                last = acc && cyc == gc + LAT;
                rdy  = busy && cyc == gc + LAT + 1;
                check(LAT, "InstReady", InstReady, rdy && !own);
                check(LAT, "DataReady", DataReady, rdy && own);
                check(LAT, "MemRead", MemRead, acc && !wr);
                check(LAT, "MemWrite", MemWrite, last && wr && !Reset);
                check(LAT, "InstData", InstData, expI);
                check(LAT, "DataRData", DataRData, expD);
                if (acc) check(LAT, "MemAddr", MemAddr, ad);
                if (acc && wr) check(LAT, "MemWData", MemWData, wd);
                if (fresh) begin
                    check(LAT, "MemAddrRst", MemAddr, 32'h0);
                    check(LAT, "MemWDataRst", MemWData, 32'h0);
                end
                if (busy && !Reset) check(LAT, "reqHeld", own ? DataReq : InstReq, 1'b1);
                if (InstReady || DataReady) ordLog.push_back(InstReady);
            end
        end

        task automatic waitReady(input bit isInst, output int rc, output int nRd, output int nWr);
            bit seen;
            seen = 1'b0; rc = -1; nRd = 0; nWr = 0;
            for (int i = 0; i < 80 && !seen; i++) begin
                @(negedge Clk);
                if (MemRead) nRd++;
                if (MemWrite) nWr++;
                if (isInst ? InstReady : DataReady) begin
                    seen = 1'b1;
                    rc = cyc;
                end
            end
            check(LAT, "readyInTime", {31'b0, seen}, 32'h1);
            @(posedge Clk); #1;
        endtask

        function automatic logic [9:0] lastOrder(input int from, input int n);
            logic [9:0] r;
            r = '0;
            for (int i = 0; i < n; i++) r = {r[8:0], ordLog[from + i]};
            return r;
        endfunction

        initial begin : stim
            int c0, rc, nr, nw, o0;
            for (int i = 0; i < 4096; i++) begin
                mem[i] = 8'(i * 7 + 3);
                refMem[i] = 8'(i * 7 + 3);
            end
            {mem[256], mem[257], mem[258], mem[259]} = 32'h12345678;
            {refMem[256], refMem[257], refMem[258], refMem[259]} = 32'h12345678;
            Reset = 1'b1; InstReq = 1'b0; DataReq = 1'b0; DataWrite = 1'b0;
            InstAddr = '0; DataAddr = '0; DataWData = '0;
            repeat (3) @(posedge Clk);
            @(negedge Clk);
            check(LAT, "rstInstReady", InstReady, 32'h0);
            check(LAT, "rstMemAddr", MemAddr, 32'h0);
            check(LAT, "rstDataRData", DataRData, 32'h0);
            @(posedge Clk); #1;
            Reset = 1'b0;

            // Lone fetch: Ready LAT+1 cycles after the request, MemRead for LAT cycles.
            c0 = cyc; InstAddr = 32'h100; InstReq = 1'b1;
            waitReady(1'b1, rc, nr, nw);
            InstReq = 1'b0;
            check(LAT, "fetchLatency", rc - c0, LAT + 1);
            check(LAT, "fetchReadCycles", nr, LAT);
            check(LAT, "fetchData", InstData, 32'h12345678);

            // Store then load of the same word.
            DataWrite = 1'b1; DataAddr = 32'h200; DataWData = 32'hDEADBEEF; DataReq = 1'b1;
            waitReady(1'b0, rc, nr, nw);
            DataReq = 1'b0;
            check(LAT, "storeWriteCycles", nw, 1);
            DataWrite = 1'b0; DataReq = 1'b1;
            waitReady(1'b0, rc, nr, nw);
            DataReq = 1'b0;
            check(LAT, "loadData", DataRData, 32'hDEADBEEF);
            check(LAT, "instDataKept", InstData, 32'h12345678);

            // Both held continuously: four data grants, then a forced fetch.
            o0 = ordLog.size();
            InstAddr = 32'h100; InstReq = 1'b1;
            DataAddr = 32'h200; DataReq = 1'b1;
            fork
                begin
                    repeat (2) waitReady(1'b1, rc, nr, nw);
                    InstReq = 1'b0;
                end
                begin
                    repeat (8) waitReady(1'b0, rc, nr, nw);
                    DataReq = 1'b0;
                end
            join
            check(LAT, "contentionCount", ordLog.size() - o0, 10);
            check(LAT, "contentionOrder", lastOrder(o0, 10), 10'b0000100001);

            // Simultaneous arrival: data first, fetch in the following IDLE.
            o0 = ordLog.size();
            InstAddr = 32'h104; InstReq = 1'b1;
            DataAddr = 32'h200; DataReq = 1'b1;
            fork
                begin waitReady(1'b1, rc, nr, nw); InstReq = 1'b0; end
                begin waitReady(1'b0, rc, nr, nw); DataReq = 1'b0; end
            join
            check(LAT, "pairOrder", lastOrder(o0, 2), 10'b01);

            // Reset landing on the final access cycle of a store.
            DataWrite = 1'b1; DataAddr = 32'h300; DataWData = 32'hCAFEF00D; DataReq = 1'b1;
            @(posedge Clk);
            repeat (LAT - 1) @(posedge Clk);
            #1 Reset = 1'b1;
            @(negedge Clk);
            check(LAT, "abortNoWrite", MemWrite, 32'h0);
            @(posedge Clk); #1;
            Reset = 1'b0; DataReq = 1'b0; DataWrite = 1'b0;
            @(negedge Clk);
            check(LAT, "abortReady", DataReady, 32'h0);
            check(LAT, "abortMemAddr", MemAddr, 32'h0);
            check(LAT, "abortMemRead", MemRead, 32'h0);
            check(LAT, "abortInstData", InstData, 32'h0);
            @(posedge Clk); #1;
            DataReq = 1'b1;
            waitReady(1'b0, rc, nr, nw);
            DataReq = 1'b0;
            DataWrite = 1'b1; DataReq = 1'b1;
            waitReady(1'b0, rc, nr, nw);
            DataReq = 1'b0; DataWrite = 1'b0;
            DataReq = 1'b1;
            waitReady(1'b0, rc, nr, nw);
            DataReq = 1'b0;
            check(LAT, "reissueLoad", DataRData, 32'hCAFEF00D);

            // Random mixed traffic, 100 requests in total.
            fork
                begin : instTraffic
                    int gap, r1, r2, r3;
                    for (int n = 0; n < 50; n++) begin
                        gap = $urandom_range(0, 3);
                        if (gap > 0) begin
                            InstReq = 1'b0;
                            repeat (gap) begin @(posedge Clk); #1; end
                        end
                        InstAddr = 32'h200 + 32'($urandom_range(0, 63));
                        InstReq = 1'b1;
                        waitReady(1'b1, r1, r2, r3);
                    end
                    InstReq = 1'b0;
                end
                begin : dataTraffic
                    int gap, r1, r2, r3;
                    for (int n = 0; n < 50; n++) begin
                        gap = $urandom_range(0, 3);
                        if (gap > 0) begin
                            DataReq = 1'b0;
                            repeat (gap) begin @(posedge Clk); #1; end
                        end
                        DataWrite = 1'($urandom_range(0, 1));
                        DataAddr  = 32'h200 + 32'($urandom_range(0, 63));
                        DataWData = $urandom;
                        DataReq   = 1'b1;
                        waitReady(1'b0, r1, r2, r3);
                    end
                    DataReq = 1'b0;
                end
            join
            repeat (4) @(posedge Clk);
            fin = 1'b1;
        end
    end

    initial begin : finisher
        bit allDone;
        allDone = 1'b0;
        for (int i = 0; i < 20000 && !allDone; i++) begin
            @(posedge Clk);
            allDone = lane[0].fin && lane[1].fin;
        end
        check(0, "benchComplete", {31'b0, allDone}, 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
